countdown_timer: RTL
====================

// Module: countdown_timer
//
// PURPOSE
// Loadable down-counter with a start/abort FSM and a registered terminal-count pulse.
// It is the counterpart to the processor's loadable up-counter.
// - Software or control logic loads a period, starts the timer, and gets DONE when it reaches zero.
// - Used for stall/timeout windows and multi-cycle operation timing in the RISC-y core.
//
// PARAMETERS
// WIDTH   5   bit width of DATA, COUNT and the internal reload register
//
// PORTS
// CLOCK   in   1      clock, rising edge
// RESET   in   1      asynchronous, active-low; clears all state
// ENABLE  in   1      active-high; when low, the FSM, COUNT and RELOAD hold
// LOAD    in   1      when high with ENABLE: COUNT<=DATA, RELOAD<=DATA
// DATA    in   WIDTH  period value captured on LOAD
// START   in   1      when high with ENABLE in IDLE: begin counting down
// ABORT   in   1      when high with ENABLE in RUN: stop, no DONE
// COUNT   out  WIDTH  current count, registered
// BUSY    out  1      high while the FSM is in RUN (decoded from the state register)
// DONE    out  1      one-CLOCK pulse, registered, on terminal count
// ZERO    out  1      COUNT == 0, combinational from COUNT
//
// BEHAVIOUR
// - Reset values: COUNT=0, RELOAD=0, state=IDLE, DONE=0, BUSY=0, ZERO=1.
// - States and transitions (only on edges with ENABLE=1):
//   - IDLE -> RUN on START when COUNT!=0.
//   - RUN -> IDLE on ABORT, or on terminal count (one-shot mode).
// - Control priority on an enabled edge: LOAD > ABORT > START > decrement.
// - LOAD in any state: COUNT<=DATA, RELOAD<=DATA, state<=IDLE. A timer in RUN is cancelled without DONE.
// - START in IDLE with COUNT==0: DONE=1 on that edge, state stays IDLE (zero-length timer).
// - START in RUN: ignored. ABORT in IDLE: ignored.
// - RUN: COUNT<=COUNT-1 on each enabled edge. At the edge where COUNT goes 1->0:
//   - DONE<=1;
//   - state<=IDLE.
// - Latency: START sampled at edge k with COUNT=N gives COUNT=0 and DONE=1 after edge k+N.
//   DONE is high for exactly one clock.
// - DONE clears on the next CLOCK edge regardless of ENABLE.
// - ENABLE=0 while DONE=1: DONE still drops after one clock.
// - Underflow is impossible: COUNT is never decremented from 0 and never wraps to all-ones.
// - ABORT in RUN: COUNT holds its current value, BUSY drops next edge. A later START resumes from COUNT.
// - ENABLE low mid-RUN: COUNT and state freeze; counting continues when ENABLE returns.
// - RESET mid-RUN: immediate return to reset values; no DONE is generated.
//
// CONFIGURATION
// Macro COUNTDOWN_AUTORELOAD_EN.
// - Defined (periodic mode):
//   - At terminal count, COUNT<=RELOAD instead of 0, DONE<=1, state stays RUN.
//   - DONE then pulses every RELOAD cycles until ABORT or LOAD.
//   - If RELOAD==1, DONE stays high continuously.
//   - If RELOAD==0, the block behaves as one-shot.
// - Undefined: one-shot only. The RELOAD register is still present but only feeds nothing.
//   Synthesis may remove it.
//
// STRUCTURE
// - Package countdown_pkg holds:
//   - typedef enum logic [0:0] {IDLE, RUN} cd_state_t;
//   - localparam CD_DEFAULT_WIDTH = 5.
// - Single module with no sub-module. The FSM and datapath are small enough to share one always_ff.
// - BUSY and ZERO are continuous assigns.
//
// TESTING (WIDTH=5)
// 1. Reset, LOAD DATA=5, START -> BUSY=1; COUNT 5,4,3,2,1,0; DONE=1 for exactly one clock with
//    COUNT=0; BUSY=0 afterwards.
// 2. LOAD 10, START, ABORT at COUNT=6 -> COUNT holds 6, BUSY=0, no DONE. START again -> DONE 6
//    cycles later.
// 3. RUN with COUNT=4, drop ENABLE for 3 clocks -> COUNT frozen at 4. Re-enable -> DONE 4 cycles
//    later. Also LOAD+ABORT+START asserted on the same edge -> LOAD wins.
// 4. START with COUNT=0 -> DONE pulse one clock, BUSY stays 0. Then RESET asserted mid-RUN
//    (COUNT=3) -> COUNT=0, DONE=0, BUSY=0 immediately, without waiting for CLOCK.
// 5. With COUNTDOWN_AUTORELOAD_EN: LOAD 3, START -> DONE pulses every 3 clocks; COUNT sequence
//    3,2,1,3,2,1... ABORT stops it.
//    Without the macro -> a single DONE only.

Source files
------------

// File: rtl/countdown_pkg.sv
// Package: countdown_pkg
// Shared types and defaults for the countdown timer.
//   cd_state_t       : FSM state encoding (IDLE, RUN)
//   CD_DEFAULT_WIDTH : default bit width of DATA/COUNT/RELOAD
package countdown_pkg;

  typedef enum logic [0:0] {IDLE, RUN} cd_state_t;

  localparam int unsigned CD_DEFAULT_WIDTH = 5;

endpackage

// File: rtl/countdown_timer.sv
// Module: countdown_timer
// Loadable down-counter with a start/abort FSM and a registered terminal-count pulse.
// Optional periodic mode is enabled by defining COUNTDOWN_AUTORELOAD_EN.
//
// Ports:
//   CLOCK  in   1      clock, rising edge
//   RESET  in   1      asynchronous, active-low; clears all state
//   ENABLE in   1      when low, FSM, COUNT and RELOAD hold
//   LOAD   in   1      with ENABLE: COUNT<=DATA, RELOAD<=DATA, back to IDLE
//   DATA   in   WIDTH  period value captured on LOAD
//   START  in   1      with ENABLE in IDLE: begin counting down
//   ABORT  in   1      with ENABLE in RUN: stop without DONE
//   COUNT  out  WIDTH  current count, registered
//   BUSY   out  1      high while in RUN
//   DONE   out  1      one-clock registered terminal-count pulse
//   ZERO   out  1      COUNT == 0
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = CD_DEFAULT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             START,
  input  logic             ABORT,
  output logic [WIDTH-1:0] COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO
);

  cd_state_t        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // DONE is a single-cycle pulse and drops even when ENABLE is low.
      done_q <= 1'b0;
      if (ENABLE) begin
        if (LOAD) begin
          count_q  <= DATA;
          reload_q <= DATA;
          state_q  <= IDLE;
        end else if (ABORT && (state_q == RUN)) begin
          state_q <= IDLE;
        end else if (START && (state_q == IDLE)) begin
          // A zero-length timer completes immediately without entering RUN.
          if (count_q == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end else if (state_q == RUN) begin
          if (count_q == '0) begin
            // Unreachable in normal operation; guards against ever wrapping.
            state_q <= IDLE;
          end else if (count_q == WIDTH'(1)) begin
            done_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (reload_q != '0) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= IDLE;
            end
`else
            count_q <= '0;
            state_q <= IDLE;
`endif
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
      end
    end
  end

`ifndef COUNTDOWN_AUTORELOAD_EN
  // One-shot build: the reload value has no consumer.
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  assign COUNT = count_q;
  assign BUSY  = (state_q == RUN);
  assign DONE  = done_q;
  assign ZERO  = (count_q == '0);

endmodule
